// File: rtl/register_file.sv
// register_file: architectural registers with ROB rename tags and operand resolution
module register_file #(
  parameter int ROB_WIDTH_BIT = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic [4:0]               commit_reg_id,
  input  logic [31:0]              commit_val,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [4:0]               new_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] new_rob_id,
  input  logic [4:0]               dec_rs1_reg,
  input  logic [4:0]               dec_rs2_reg,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
  input  logic                     rob_rs1_ready,
  input  logic                     rob_rs2_ready,
  input  logic [31:0]              rob_rs1_val,
  input  logic [31:0]              rob_rs2_val,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic                     rs1_has_dep,
  output logic                     rs2_has_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs2_dep
);
  logic [31:0]              value [32];
  logic                     busy  [32];
  logic [ROB_WIDTH_BIT-1:0] tag   [32];
  // Rename is applied after commit so it wins on the same register; x0 is never addressed
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value[i] <= '0;
        busy[i]  <= 1'b0;
        tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_reg_id != 5'd0) begin
        value[commit_reg_id] <= commit_val;
        if (busy[commit_reg_id] && tag[commit_reg_id] == commit_rob_id) busy[commit_reg_id] <= 1'b0;
      end
      if (clear_in) begin
        for (int i = 0; i < 32; i++) busy[i] <= 1'b0;
      end else if (new_reg_id != 5'd0) begin
        busy[new_reg_id] <= 1'b1;
        tag[new_reg_id]  <= new_rob_id;
      end
    end
  end
  logic b1, b2;
  assign b1          = busy[dec_rs1_reg];
  assign b2          = busy[dec_rs2_reg];
  assign rob_rs1_id  = b1 ? tag[dec_rs1_reg] : '0;
  assign rob_rs2_id  = b2 ? tag[dec_rs2_reg] : '0;
  assign rs1_has_dep = b1 && !rob_rs1_ready;
  assign rs2_has_dep = b2 && !rob_rs2_ready;
  assign rs1_dep     = rs1_has_dep ? tag[dec_rs1_reg] : '0;
  assign rs2_dep     = rs2_has_dep ? tag[dec_rs2_reg] : '0;
  assign rs1_val     = dec_rs1_reg == 5'd0 ? '0 : !b1 ? value[dec_rs1_reg] : rob_rs1_ready ? rob_rs1_val : '0;
  assign rs2_val     = dec_rs2_reg == 5'd0 ? '0 : !b2 ? value[dec_rs2_reg] : rob_rs2_ready ? rob_rs2_val : '0;
endmodule
